// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN_H,
        LEN_L,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef logic [15:0] len_t;

    // States in which the loader takes bytes from the host link.
    function automatic logic accepts_bytes(state_t s);
        return (s inside {SYNC, LEN_H, LEN_L, DATA, CHK});
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream from the host link bridge into the loader (valid/ready).
interface imem_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/imem_loader_chk.sv
// Running 8-bit XOR of the payload; clear has priority over enable.
module loader_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from the host byte stream into instruction memory
// and keeps the core halted until a checksum-verified image is in place.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  SYNC  | hunting for the frame marker, other bytes dropped
//  LEN_H | expecting payload length high byte
//  LEN_L | expecting payload length low byte, range check
//  DATA  | writing payload bytes to memory
//  CHK   | expecting XOR checksum byte
//  DONE  | image good, core released
//  ERR   | image rejected, core held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 256,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      host,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0]       MAX_LEN = 17'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q;
    len_t              rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        chk_acc;
    len_t              len_full;
    logic              ready, accept, start_ok;
    logic              chk_clr, wr, set_done, set_err;

    assign ready        = accepts_bytes(state_q);
    assign host.s_ready = ready;
    assign accept       = ready & host.s_valid;
    assign start_ok     = start & (state_q inside {IDLE, DONE, ERR});
    assign len_full     = {len_hi_q, host.s_data};
    assign busy         = ready;
    // The core may only run while the last frame is known good.
    assign core_hold    = ~done;

    loader_chk u_chk (
        .clk (clk),
        .rst (rst),
        .clr (chk_clr),
        .en  (wr),
        .din (host.s_data),
        .acc (chk_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chk_clr  = 1'b0;
        wr       = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_ok) state_d = SYNC;
            end
            SYNC: begin
                if (accept && host.s_data == SYNC_BYTE) begin
                    state_d = LEN_H;
                    chk_clr = 1'b1;
                end
            end
            LEN_H: begin
                if (accept) state_d = LEN_L;
            end
            LEN_L: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_LEN) begin
                        state_d = ERR;
                        set_err = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr = 1'b1;
                    if (rem_q == 16'd1) state_d = CHK;
                end
            end
            CHK: begin
                if (accept) begin
                    if (host.s_data == chk_acc) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d = ERR;
                        set_err = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            addr_q    <= '0;
            rem_q     <= '0;
            len_hi_q  <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= wr;
            if (wr) begin
                mem_addr  <= addr_q;
                mem_wdata <= host.s_data;
                addr_q    <= addr_q + ADDR_W'(1);
                rem_q     <= rem_q - 16'd1;
            end
            if (chk_clr) addr_q <= BASE;
            if (state_q == LEN_H && accept) len_hi_q <= host.s_data;
            // rem_q is a down-counter; the byte accepted with rem_q==1 is the last one.
            if (state_q == LEN_L && accept) rem_q <= len_full;
            if (start_ok) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, sync hunting, length/checksum errors,
// stalled streams and asynchronous reset mid-frame.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_hold, busy, done, err;

    imem_loader_if host ();

    imem_loader #(
        .ADDR_W    (8),
        .DEPTH     (256),
        .BASE_ADDR (0),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .host      (host.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         wr_n = 0;
    logic [7:0] wr_addr [16];
    logic [7:0] wr_data [16];
    int         wr_cyc  [16];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        host.s_valid = 1'b1;
        host.s_data  = b;
        while (host.s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        host.s_valid = 1'b0;
        host.s_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) begin
            if (max_gap > 0) begin
                int gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    host.s_valid = 1'b0;
                    host.s_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            send_byte(bytes[i]);
        end
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] exp_data[$], input logic contiguous);
        check({tag, "_wr_count"}, 32'(wr_n), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < wr_n && i < 16; i++) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
            check({tag, "_data"}, 32'(wr_data[i]), 32'(exp_data[i]));
            if (contiguous && i > 0)
                check({tag, "_b2b"}, 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd1);
        end
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err,
                                input logic e_hold, input logic e_busy);
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_err"}, 32'(err), 32'(e_err));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(e_hold));
        check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(host.s_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        host.s_valid = 1'b0;
        host.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Basic load of a 4-byte image
        wr_n = 0;
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_ready_after_start", 32'(host.s_ready), 32'd1);
        send_frame('{8'hA5, 8'h00, 8'h04, 8'h00, 8'hE2, 8'h00, 8'h01, 8'hE3}, 0);
        check_writes("t1", '{8'h00, 8'hE2, 8'h00, 8'h01}, 1'b1);
        check_status("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_ready_done", 32'(host.s_ready), 32'd0);

        // Garbage before marker is dropped
        wr_n = 0;
        pulse_start();
        check_status("t2_start", 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame('{8'h12, 8'h34}, 0);
        check("t2_no_write_junk", 32'(wr_n), 32'd0);
        check("t2_still_hunting", 32'(busy), 32'd1);
        send_frame('{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h66}, 0);
        check_writes("t2", '{8'hAB, 8'hCD}, 1'b1);
        check_status("t2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Length one past memory size is rejected with no writes
        wr_n = 0;
        pulse_start();
        send_frame('{8'hA5, 8'h01, 8'h01}, 0);
        check("t3_no_writes", 32'(wr_n), 32'd0);
        check_status("t3", 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_ready_err", 32'(host.s_ready), 32'd0);

        // Zero-length frame goes straight to checksum
        wr_n = 0;
        pulse_start();
        check("t3b_err_cleared", 32'(err), 32'd0);
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        check("t3b_no_writes", 32'(wr_n), 32'd0);
        check_status("t3b", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bad checksum: bytes still written, frame rejected
        wr_n = 0;
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h00}, 0);
        check_writes("t4", '{8'h11, 8'h22}, 1'b1);
        check_status("t4", 1'b0, 1'b1, 1'b1, 1'b0);

        // Stalled stream with random gaps and junk on s_data while invalid
        wr_n = 0;
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h06, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70}, 2);
        check_writes("t5", '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}, 1'b0);
        check_status("t5", 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after two payload bytes
        wr_n = 0;
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h04, 8'hAA, 8'hBB}, 0);
        check("t6_partial_writes", 32'(wr_n), 32'd2);
        check("t6_busy_mid", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_n = 0;
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00}, 0);
        check_writes("t6", '{8'h01, 8'h02, 8'h03}, 1'b1);
        check_status("t6", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
